// File: rtl/cpu_controller_pkg.sv
// Shared encodings for the ARM-subset sequencing controller: FSM states,
// condition codes, shifter/ALU opcodes and instruction-class decode.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CLS_DP0 = 2'd0,
    CLS_DP1 = 2'd1,
    CLS_DP2 = 2'd2,
    CLS_INV = 2'd3
  } instr_class_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Shifter opcode is {type, by_register}
  localparam logic [2:0] SH_LSL_IMM = 3'b000;
  localparam logic [2:0] SH_LSL_REG = 3'b001;
  localparam logic [2:0] SH_LSR_IMM = 3'b010;
  localparam logic [2:0] SH_LSR_REG = 3'b011;
  localparam logic [2:0] SH_ASR_IMM = 3'b100;
  localparam logic [2:0] SH_ASR_REG = 3'b101;
  localparam logic [2:0] SH_ROR_IMM = 3'b110;
  localparam logic [2:0] SH_ROR_REG = 3'b111;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_EOR = 4'b0001;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_RSB = 4'b0011;
  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_ADC = 4'b0101;
  localparam logic [3:0] ALU_SBC = 4'b0110;
  localparam logic [3:0] ALU_RSC = 4'b0111;
  localparam logic [3:0] ALU_TST = 4'b1000;
  localparam logic [3:0] ALU_TEQ = 4'b1001;
  localparam logic [3:0] ALU_CMP = 4'b1010;
  localparam logic [3:0] ALU_CMN = 4'b1011;
  localparam logic [3:0] ALU_ORR = 4'b1100;
  localparam logic [3:0] ALU_MOV = 4'b1101;
  localparam logic [3:0] ALU_BIC = 4'b1110;
  localparam logic [3:0] ALU_MVN = 4'b1111;

  localparam logic [1:0] RS_SRC_IMM5 = 2'b00;
  localparam logic [1:0] RS_SRC_RS   = 2'b01;
  localparam logic [1:0] RS_SRC_ROT  = 2'b10;

  function automatic instr_class_e decode_class(input logic [31:0] ir);
    instr_class_e cls;
    cls = CLS_INV;
    if (ir[27:25] == 3'b001) begin
      cls = CLS_DP2;
    end else if (ir[27:25] == 3'b000 && ir[4] == 1'b0) begin
      cls = CLS_DP0;
    end else if (ir[27:25] == 3'b000 && ir[7] == 1'b0) begin
      cls = CLS_DP1;
    end else begin
      cls = CLS_INV;
    end
    return cls;
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Control/status bundle between the sequencing controller (master) and the
// datapath (slave).
interface cpu_controller_if;
  logic [31:0] IR;
  logic [3:0]  NZCV;
  logic        write_pc;
  logic        write_ir;
  logic        write_reg;
  logic        write_nzcv;
  logic        rm_imm_s_ctrl;
  logic [1:0]  rs_imm_s_ctrl;
  logic [3:0]  ALU_OP_ctrl;
  logic [2:0]  Shift_OP_ctrl;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  modport master (
    input  IR, NZCV,
    output write_pc, write_ir, write_reg, write_nzcv,
    output rm_imm_s_ctrl, rs_imm_s_ctrl, ALU_OP_ctrl, Shift_OP_ctrl,
    output state, instr_cnt
  );

  modport slave (
    output IR, NZCV,
    input  write_pc, write_ir, write_reg, write_nzcv,
    input  rm_imm_s_ctrl, rs_imm_s_ctrl, ALU_OP_ctrl, Shift_OP_ctrl,
    input  state, instr_cnt
  );
endinterface

// File: rtl/cpu_controller_cond_check.sv
// ARM condition-field evaluation against the current NZCV flags.
// The reserved 1111 encoding never passes.
module cond_check
  import cpu_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       pass
);

  logic n_s, z_s, c_s, v_s;
  assign {n_s, z_s, c_s, v_s} = nzcv;

  // condition table lookup
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z_s;
      COND_NE: pass = ~z_s;
      COND_CS: pass = c_s;
      COND_CC: pass = ~c_s;
      COND_MI: pass = n_s;
      COND_PL: pass = ~n_s;
      COND_VS: pass = v_s;
      COND_VC: pass = ~v_s;
      COND_HI: pass = c_s & ~z_s;
      COND_LS: pass = ~c_s | z_s;
      COND_GE: pass = (n_s == v_s);
      COND_LT: pass = (n_s != v_s);
      COND_GT: pass = ~z_s & (n_s == v_s);
      COND_LE: pass = z_s | (n_s != v_s);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the ARM-subset datapath.
// Control outputs are Moore-decoded from the state register and the live IR.
module cpu_controller
  import cpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  cpu_controller_if.master bus
);

  state_e       state_r;
  state_e       next_state_s;
  logic [31:0]  instr_cnt_r;
  logic         cond_pass_s;
  instr_class_e class_s;
  logic         is_test_s;
  logic         unused_ir_s;

  logic         write_pc_s;
  logic         write_ir_s;
  logic         write_reg_s;
  logic         write_nzcv_s;
  logic         rm_imm_s;
  logic [1:0]   rs_imm_s;
  logic [3:0]   alu_op_s;
  logic [2:0]   shift_op_s;

  cond_check u_cond_check (
    .cond (bus.IR[31:28]),
    .nzcv (bus.NZCV),
    .pass (cond_pass_s)
  );

  assign class_s     = decode_class(bus.IR);
  // TST/TEQ/CMP/CMN share opcode prefix 10 and only update flags
  assign is_test_s   = (bus.IR[24:23] == ALU_TST[3:2]);
  assign unused_ir_s = ^{bus.IR[19:8], bus.IR[3:0]};

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // retired-instruction counter, bumped on the edge leaving write-back
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_cnt_r <= 32'd0;
    end else if (state_r == ST_WB) begin
      instr_cnt_r <= instr_cnt_r + 32'd1;
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end

  // next-state decision; invalid classes behave like a failed condition
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE:   next_state_s = ST_FETCH;
      ST_FETCH:  next_state_s = ST_DECODE;
      ST_DECODE: begin
        if (cond_pass_s && (class_s != CLS_INV)) begin
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_FETCH;
        end
      end
      ST_EXEC:   next_state_s = ST_WB;
      ST_WB:     next_state_s = ST_FETCH;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    write_pc_s   = 1'b0;
    write_ir_s   = 1'b0;
    write_reg_s  = 1'b0;
    write_nzcv_s = 1'b0;
    rm_imm_s     = 1'b0;
    rs_imm_s     = 2'b00;
    alu_op_s     = 4'b0000;
    shift_op_s   = 3'b000;
    case (state_r)
      ST_FETCH: begin
        write_pc_s = 1'b1;
        write_ir_s = 1'b1;
      end
      ST_DECODE, ST_EXEC, ST_WB: begin
        alu_op_s = bus.IR[24:21];
        case (class_s)
          CLS_DP0: begin
            rs_imm_s   = RS_SRC_IMM5;
            shift_op_s = {bus.IR[6:5], 1'b0};
          end
          CLS_DP1: begin
            rs_imm_s   = RS_SRC_RS;
            shift_op_s = {bus.IR[6:5], 1'b1};
          end
          CLS_DP2: begin
            rm_imm_s   = 1'b1;
            rs_imm_s   = RS_SRC_ROT;
            shift_op_s = SH_ROR_REG;
          end
          default: begin
            rs_imm_s   = 2'b00;
            shift_op_s = 3'b000;
          end
        endcase
        if (state_r == ST_WB) begin
          write_reg_s  = ~is_test_s;
          write_nzcv_s = bus.IR[20] | is_test_s;
        end else begin
          write_reg_s  = 1'b0;
          write_nzcv_s = 1'b0;
        end
      end
      default: begin
        write_pc_s = 1'b0;
        write_ir_s = 1'b0;
      end
    endcase
  end

  assign bus.write_pc      = write_pc_s;
  assign bus.write_ir      = write_ir_s;
  assign bus.write_reg     = write_reg_s;
  assign bus.write_nzcv    = write_nzcv_s;
  assign bus.rm_imm_s_ctrl = rm_imm_s;
  assign bus.rs_imm_s_ctrl = rs_imm_s;
  assign bus.ALU_OP_ctrl   = alu_op_s;
  assign bus.Shift_OP_ctrl = shift_op_s;
  assign bus.state         = state_r;
  assign bus.instr_cnt     = instr_cnt_r;

endmodule

// File: doc/cpu_controller.md
# cpu_controller

Multi-cycle sequencing FSM for the single-issue ARM-subset CPU datapath (register file, barrel shifter, ALU, IR/PC registers). It steps each data-processing instruction through fetch, decode, execute and write-back, and evaluates the ARM condition field against NZCV. It drives the datapath control signals (write enables, operand-select muxes, ALU and shift opcodes) and exposes state and a retired-instruction counter for board-level LED and seven-segment debug.

## Interface
- No parameters.
- `clk` in 1: single system clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `IR` in 32: current instruction register contents, written by the datapath when `write_ir` is high.
- `NZCV` in 4: current flags {N,Z,C,V}.
- `write_pc` out 1: PC ← PC+4 strobe.
- `write_ir` out 1: IR ← memory[PC] strobe.
- `write_reg` out 1: register-file write of F to Rd (IR[15:12]).
- `write_nzcv` out 1: flag-register update strobe.
- `rm_imm_s_ctrl` out 1: 0 = shifter input from Rm, 1 = from zero-extended IR[7:0].
- `rs_imm_s_ctrl` out 2: shift-amount source. 00 = IR[11:7]; 01 = Rs[7:0]; 10 = {IR[11:8],1'b0}; 11 unused.
- `ALU_OP_ctrl` out 4: ALU opcode.
- `Shift_OP_ctrl` out 3: shifter opcode.
- `state` out 3: current FSM state encoding.
- `instr_cnt` out 32: count of executed (condition-passed) instructions.

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4.
- Transitions: IDLE→FETCH; FETCH→DECODE; DECODE→EXEC when the condition passes and the class is valid, otherwise DECODE→FETCH; EXEC→WB; WB→FETCH. Encodings 5–7 → IDLE.
- Classes:
  - DP0: IR[27:25]=000, IR[4]=0.
  - DP1: IR[27:25]=000, IR[7]=0, IR[4]=1.
  - DP2: IR[27:25]=001.
  - Anything else is invalid and treated as a failed condition (NOP).
- Condition: standard ARM cond IR[31:28] (EQ…AL). 1111 counts as fail.
- FETCH: `write_ir`=`write_pc`=1.
- DECODE/EXEC/WB: the mux and opcode outputs are valid and held.
  - `ALU_OP_ctrl`=IR[24:21].
  - `rm_imm_s_ctrl`=1 for DP2 only.
  - `rs_imm_s_ctrl`: DP0=00, DP1=01, DP2=10.
  - `Shift_OP_ctrl`: DP0={IR[6:5],0}, DP1={IR[6:5],1}, DP2=3'b111.
- WB:
  - `write_reg`=1 unless IR[24:23]=10 (TST/TEQ/CMP/CMN).
  - `write_nzcv`=IR[20] | (IR[24:23]==10).
  - `instr_cnt` increments by 1 on the edge leaving WB.
- Outside the active states, all mux and opcode outputs are 0.
- `instr_cnt` wraps modulo 2^32.

## Timing
- Reset: asserting `rst` immediately forces state=IDLE, `instr_cnt`=0, and all outputs to 0. IDLE lasts one cycle after deassertion.
- Outputs are Moore-decoded from the state register and IR. There is no combinational path from NZCV to the write strobes except through the DECODE→next-state decision.
- Executed instruction: 4 cycles (FETCH, DECODE, EXEC, WB). Skipped instruction: 2 cycles (FETCH, DECODE).
- IR changes on the edge ending FETCH. The DECODE condition check uses the new IR and the NZCV value present in DECODE.
- Flags written at the WB edge are visible to the next instruction's DECODE.
- `write_reg` and `write_nzcv` are exactly one-cycle pulses. `write_ir` and `write_pc` are each one cycle per instruction.
- Reset mid-instruction abandons it: no write pulse is issued and the counter is not incremented.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - state encodings;
  - cond-code constants (EQ=0000 … AL=1110);
  - shift-op encodings (LSL/LSR/ASR/ROR × imm/reg);
  - ALU opcode constants;
  - the `rs_imm_s_ctrl` source codes.
- Sub-module `cond_check`: combinational (cond[3:0], NZCV[3:0]) → pass.

## Test plan
- Reset and start: hold rst=0 → state=0, all strobes 0, instr_cnt=0. Release → IDLE for 1 cycle, then FETCH with write_ir=write_pc=1.
- ADD, shift-by-immediate: IR=0xE0812003 → ALU_OP=0100, rm_imm=0, rs_imm=00, Shift_OP=000. WB gives write_reg=1, write_nzcv=0. 4 cycles; instr_cnt=1.
- SUBS, immediate: IR=0xE2533001 → rm_imm=1, rs_imm=10, Shift_OP=111, ALU_OP=0010. WB gives write_reg=1, write_nzcv=1.
- Register shift and CMP:
  - IR=0xE0812153 → rs_imm=01, Shift_OP=101.
  - IR=0xE1530004 → ALU_OP=1010, WB gives write_reg=0, write_nzcv=1.
- Condition and reset mid-operation:
  - IR=0x00812003 with NZCV=0000 → DECODE→FETCH, no strobes, instr_cnt unchanged.
  - Same IR with NZCV=0100 → executes normally.
  - Pulling rst low during EXEC → IDLE, with no write_reg pulse.
